// File: rtl/lacr_rx_if.sv
// Receive-side bus for the link configuration parser.
// The decoded byte stream (rx_data/rx_is_k/rx_err) arrives one byte per rx_clk
// with no backpressure: every cycle carries a byte and the parser must consume
// it. The outputs are registered status; lacr_stb and idle_stb are single-cycle
// strobes with no acknowledge. dbg_* expose parser state and counters for
// observation only.
interface lacr_rx_if;
  logic [7:0]  rx_data;
  logic        rx_is_k;
  logic        rx_err;
  logic [15:0] lacr_val;
  logic        lacr_stb;
  logic        idle_stb;
  logic        los;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_err_cnt;
  logic [15:0] dbg_comma_timer;

  // Byte source side (PCS decoder / testbench).
  modport master (
    output rx_data, rx_is_k, rx_err,
    input  lacr_val, lacr_stb, idle_stb, los,
    input  dbg_state, dbg_err_cnt, dbg_comma_timer
  );

  // Parser side.
  modport slave (
    input  rx_data, rx_is_k, rx_err,
    output lacr_val, lacr_stb, idle_stb, los,
    output dbg_state, dbg_err_cnt, dbg_comma_timer
  );
endinterface

// File: rtl/lacr_rx.sv
// Parses the decoded 8b10b receive stream into /C1/ /C2/ configuration sets
// and /I1/ /I2/ idle sets, delivers each configuration word as a one-cycle
// strobe, and derives a loss-of-signal flag from decode errors and from the
// absence of completed ordered sets.
module lacr_rx #(
  parameter int unsigned COMMA_TIMEOUT = 1024,
  parameter int unsigned ERR_LIMIT     = 4
) (
  input logic       rx_clk,
  input logic       rst,
  lacr_rx_if.slave  bus
);

  localparam logic [7:0]  K28_5  = 8'hBC;
  localparam logic [7:0]  D21_5  = 8'hB5;
  localparam logic [7:0]  D2_2   = 8'h42;
  localparam logic [7:0]  D5_6   = 8'hC5;
  localparam logic [7:0]  D16_2  = 8'h50;
  localparam logic [3:0]  ERR_MAX = 4'(ERR_LIMIT);
  localparam logic [15:0] TMO_MAX = 16'(COMMA_TIMEOUT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    K      = 2'd1,
    CFG_LO = 2'd2,
    CFG_HI = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] val_q, val_d;
  logic        lacr_stb_q, lacr_stb_d;
  logic        idle_stb_q, idle_stb_d;
  logic        los_q, los_d;
  logic [3:0]  err_cnt_q, err_cnt_d;
  logic [15:0] timer_q, timer_d;

  logic is_comma, is_cfg_id, is_idle_id;
  logic cfg_done, idle_done, valid_set;

  assign is_comma   = bus.rx_is_k && (bus.rx_data == K28_5);
  assign is_cfg_id  = !bus.rx_is_k && ((bus.rx_data == D21_5) || (bus.rx_data == D2_2));
  assign is_idle_id = !bus.rx_is_k && ((bus.rx_data == D5_6) || (bus.rx_data == D16_2));

  // Parser next state: an errored byte always drops back to HUNT and is
  // otherwise ignored; a comma anywhere restarts the set.
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    val_d      = val_q;
    cfg_done   = 1'b0;
    idle_done  = 1'b0;
    if (bus.rx_err) begin
      state_d = HUNT;
    end else begin
      case (state_q)
        HUNT: begin
          if (is_comma) state_d = K;
        end
        K: begin
          if (is_comma) begin
            state_d = K;
          end else if (is_cfg_id) begin
            state_d = CFG_LO;
          end else if (is_idle_id) begin
            state_d   = HUNT;
            idle_done = 1'b1;
          end else begin
            state_d = HUNT;
          end
        end
        CFG_LO: begin
          if (bus.rx_is_k) begin
            state_d = is_comma ? K : HUNT;
          end else begin
            lo_d    = bus.rx_data;
            state_d = CFG_HI;
          end
        end
        CFG_HI: begin
          if (bus.rx_is_k) begin
            state_d = is_comma ? K : HUNT;
          end else begin
            val_d    = {bus.rx_data, lo_q};
            cfg_done = 1'b1;
            state_d  = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign valid_set = cfg_done || idle_done;

  // Strobes, error/comma counters and loss-of-signal next values. A valid set
  // clears both counters, so it also wins over a coincident los set condition.
  always_comb begin
    lacr_stb_d = cfg_done;
    idle_stb_d = idle_done;

    if (bus.rx_err) begin
      err_cnt_d = (err_cnt_q >= ERR_MAX) ? ERR_MAX : err_cnt_q + 4'd1;
    end else if (valid_set) begin
      err_cnt_d = 4'd0;
    end else begin
      err_cnt_d = err_cnt_q;
    end

    if (valid_set) begin
      timer_d = 16'd0;
    end else if (timer_q >= TMO_MAX) begin
      timer_d = TMO_MAX;
    end else begin
      timer_d = timer_q + 16'd1;
    end

    if (valid_set) begin
      los_d = 1'b0;
    end else if ((err_cnt_q == ERR_MAX) || (timer_q == TMO_MAX)) begin
      los_d = 1'b1;
    end else begin
      los_d = los_q;
    end
  end

  // Register all parser state and outputs; reset discards any partial word.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      lo_q       <= 8'd0;
      val_q      <= 16'd0;
      lacr_stb_q <= 1'b0;
      idle_stb_q <= 1'b0;
      los_q      <= 1'b1;
      err_cnt_q  <= 4'd0;
      timer_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      val_q      <= val_d;
      lacr_stb_q <= lacr_stb_d;
      idle_stb_q <= idle_stb_d;
      los_q      <= los_d;
      err_cnt_q  <= err_cnt_d;
      timer_q    <= timer_d;
    end
  end

  assign bus.lacr_val        = val_q;
  assign bus.lacr_stb        = lacr_stb_q;
  assign bus.idle_stb        = idle_stb_q;
  assign bus.los             = los_q;
  assign bus.dbg_state       = state_q;
  assign bus.dbg_err_cnt     = err_cnt_q;
  assign bus.dbg_comma_timer = timer_q;

endmodule

// File: tb/tb_lacr_rx.sv
// Bench for lacr_rx: directed scenarios followed by a randomized byte stream,
// all checked cycle by cycle against a window-matching reference model.
module tb_lacr_rx;
  localparam int TO  = 16;
  localparam int LIM = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  lacr_rx_if bus();

  lacr_rx #(.COMMA_TIMEOUT(TO), .ERR_LIMIT(LIM)) dut (
    .rx_clk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       e;
  } rx_byte_t;

  rx_byte_t    hist[$];          // last four bytes since reset
  logic [15:0] exp_q[$];         // expected config words, in order
  logic [15:0] m_val;
  logic        m_lstb, m_istb, m_los;
  int          m_errs, m_since;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_comma(input rx_byte_t b);
    return b.k && !b.e && (b.d == 8'hBC);
  endfunction

  function automatic bit is_clean_data(input rx_byte_t b);
    return !b.k && !b.e;
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    m_val = 16'h0; m_lstb = 1'b0; m_istb = 1'b0; m_los = 1'b1;
    m_errs = 0; m_since = 0;
  endtask

  // A comma always restarts the parser, so a set completes exactly when the
  // most recent bytes form a clean K28.5-led pattern.
  task automatic model_step(input rx_byte_t b);
    bit cfg, idl;
    int n;
    hist.push_back(b);
    if (hist.size() > 4) void'(hist.pop_front());
    n = hist.size();
    cfg = (n == 4) && is_comma(hist[0]) && is_clean_data(hist[1]) &&
          ((hist[1].d == 8'hB5) || (hist[1].d == 8'h42)) &&
          is_clean_data(hist[2]) && is_clean_data(hist[3]);
    idl = (n >= 2) && is_comma(hist[n-2]) && is_clean_data(hist[n-1]) &&
          ((hist[n-1].d == 8'hC5) || (hist[n-1].d == 8'h50));
    m_los = (cfg || idl) ? 1'b0 : ((m_errs >= LIM || m_since >= TO) ? 1'b1 : m_los);
    if (b.e) m_errs = (m_errs < LIM) ? m_errs + 1 : LIM;
    else if (cfg || idl) m_errs = 0;
    m_since = (cfg || idl) ? 0 : ((m_since < TO) ? m_since + 1 : TO);
    m_lstb = cfg;
    m_istb = idl;
    if (cfg) begin
      m_val = {hist[3].d, hist[2].d};
      exp_q.push_back(m_val);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [7:0] d, input logic k, input logic e);
    rx_byte_t b;
    bus.rx_data = d; bus.rx_is_k = k; bus.rx_err = e;
    @(posedge clk); #1;
    b.d = d; b.k = k; b.e = e;
    model_step(b);
    check("lacr_stb", bus.lacr_stb, m_lstb);
    check("idle_stb", bus.idle_stb, m_istb);
    check("lacr_val", bus.lacr_val, m_val);
    check("los", bus.los, m_los);
    check("err_cnt", bus.dbg_err_cnt, m_errs);
    check("comma_timer", bus.dbg_comma_timer, m_since);
    if (bus.lacr_stb === 1'b1) begin
      if (exp_q.size() > 0) check("sb_val", bus.lacr_val, exp_q.pop_front());
      else check("sb_unexpected_stb", bus.lacr_stb, 1'b0);
    end
  endtask

  task automatic send_cfg(input logic [7:0] id, input logic [7:0] lo, input logic [7:0] hi);
    step(8'hBC, 1'b1, 1'b0);
    step(id, 1'b0, 1'b0);
    step(lo, 1'b0, 1'b0);
    step(hi, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_val"}, bus.lacr_val, 16'h0000);
    check({tag, "_lstb"}, bus.lacr_stb, 1'b0);
    check({tag, "_istb"}, bus.idle_stb, 1'b0);
    check({tag, "_los"}, bus.los, 1'b1);
    check({tag, "_state"}, bus.dbg_state, 2'd0);
    check({tag, "_err"}, bus.dbg_err_cnt, 4'd0);
    check({tag, "_tmr"}, bus.dbg_comma_timer, 16'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.rx_data = 8'h00; bus.rx_is_k = 1'b0; bus.rx_err = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    #1 rst = 1'b0;

    // Config capture right after reset.
    send_cfg(8'hB5, 8'h20, 8'h40);
    check("c1_val", bus.lacr_val, 16'h4020);
    check("c1_stb", bus.lacr_stb, 1'b1);
    check("c1_los", bus.los, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("c1_stb_one_cycle", bus.lacr_stb, 1'b0);

    // /C2/ repeated, then breaklink.
    repeat (3) begin
      send_cfg(8'h42, 8'h20, 8'h00);
      check("c2_val", bus.lacr_val, 16'h0020);
    end
    send_cfg(8'hB5, 8'h00, 8'h00);
    check("break_val", bus.lacr_val, 16'h0000);
    check("break_stb", bus.lacr_stb, 1'b1);

    // Idle sets alternate /I1/ /I2/.
    repeat (3) begin
      step(8'hBC, 1'b1, 1'b0);
      step(8'hC5, 1'b0, 1'b0);
      check("i1_stb", bus.idle_stb, 1'b1);
      step(8'hBC, 1'b1, 1'b0);
      step(8'h50, 1'b0, 1'b0);
      check("i2_stb", bus.idle_stb, 1'b1);
      check("idle_no_lstb", bus.lacr_stb, 1'b0);
    end

    // Error on the hi byte aborts the word.
    send_cfg(8'hB5, 8'h01, 8'h02);
    step(8'hBC, 1'b1, 1'b0);
    step(8'hB5, 1'b0, 1'b0);
    step(8'h20, 1'b0, 1'b0);
    step(8'h40, 1'b0, 1'b1);
    check("abort_stb", bus.lacr_stb, 1'b0);
    check("abort_err", bus.dbg_err_cnt, 4'd1);
    check("abort_val", bus.lacr_val, 16'h0201);

    // Comma restart inside a set.
    step(8'hBC, 1'b1, 1'b0);
    step(8'hB5, 1'b0, 1'b0);
    send_cfg(8'hB5, 8'h11, 8'h22);
    check("restart_val", bus.lacr_val, 16'h2211);

    // Loss of signal from decode errors.
    step(8'hBC, 1'b1, 1'b0);
    step(8'hC5, 1'b0, 1'b0);
    check("err_los_clear", bus.los, 1'b0);
    repeat (LIM) step(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
    step(8'h00, 1'b0, 1'b0);
    check("err_los_set", bus.los, 1'b1);
    step(8'hBC, 1'b1, 1'b0);
    step(8'hC5, 1'b0, 1'b0);
    check("err_los_recover", bus.los, 1'b0);

    // Loss of signal from comma timeout, held with no activity.
    repeat (TO + 8) step(8'h00, 1'b0, 1'b0);
    check("tmo_los", bus.los, 1'b1);
    check("tmo_sat", bus.dbg_comma_timer, 16'(TO));

    // Randomized stream of sets, junk and silences.
    repeat (200) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        step(8'hBC, 1'b1, 1'($urandom_range(0, 15) == 0));
        step(($urandom_range(0, 1) != 0) ? 8'hB5 : 8'h42, 1'b0, 1'($urandom_range(0, 15) == 0));
        step(8'($urandom_range(0, 255)), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0));
        step(8'($urandom_range(0, 255)), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0));
      end else if (kind <= 6) begin
        step(8'hBC, 1'b1, 1'($urandom_range(0, 15) == 0));
        step(($urandom_range(0, 1) != 0) ? 8'hC5 : 8'h50, 1'b0, 1'($urandom_range(0, 15) == 0));
      end else if (kind <= 8) begin
        step(($urandom_range(0, 3) == 0) ? 8'hBC : 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
      end else begin
        repeat ($urandom_range(1, 24)) step(8'h00, 1'b0, 1'b0);
      end
    end

    // Asynchronous reset in the middle of a set.
    step(8'hBC, 1'b1, 1'b0);
    step(8'hB5, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    step(8'h11, 1'b0, 1'b0);
    step(8'h22, 1'b0, 1'b0);
    check("post_rst_no_stb", bus.lacr_stb, 1'b0);
    send_cfg(8'hB5, 8'h11, 8'h22);
    check("post_rst_val", bus.lacr_val, 16'h2211);

    step(8'h00, 1'b0, 1'b0);
    check("sb_drain", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lacr_rx.md
# lacr_rx

- Upstream neighbour of the PCS autonegotiation state machine.
- Parses the 8b10b-decoded receive byte stream into /C1/ /C2/ configuration ordered sets and /I1/ /I2/ idle ordered sets.
- Delivers each received 16-bit configuration register as a single-cycle strobe (feeds `lacr_in` / `lacr_in_stb`).
- Derives a loss-of-signal flag from decode errors and missing commas (feeds `los`).

## Interface

Parameters:
- COMMA_TIMEOUT, 1024 — cycles without a completed ordered set before `los` asserts; legal range 2..65535.
- ERR_LIMIT, 4 — consecutive-ish decode errors (cleared only by a completed ordered set) before `los` asserts; legal range 1..15.

Ports:
- rx_clk  in  1  byte clock, 125 MHz, one decoded byte per cycle
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  8  decoded byte
- rx_is_k  in  1  byte is a K character
- rx_err  in  1  code-group or disparity error on this byte
- lacr_val  out  16  last received config register, {hi byte, lo byte}
- lacr_stb  out  1  one-cycle strobe: lacr_val updated
- idle_stb  out  1  one-cycle strobe: /I1/ or /I2/ completed
- los  out  1  loss of signal / sync

## Operation

- Character codes:
  - K28.5 = 0xBC with rx_is_k=1.
  - D21.5 = 0xB5 (/C1/), D2.2 = 0x42 (/C2/).
  - D5.6 = 0xC5 (/I1/), D16.2 = 0x50 (/I2/).
  - All second/third/fourth bytes require rx_is_k=0.
- Parser FSM states: HUNT, K, CFG_LO, CFG_HI.
  - HUNT: K28.5 -> K; anything else stays in HUNT.
  - K:
    - D21.5 or D2.2 -> CFG_LO.
    - D5.6 or D16.2 -> HUNT, with idle completion.
    - K28.5 -> K (restart).
    - Anything else -> HUNT.
  - CFG_LO: a data byte is captured as lo byte -> CFG_HI.
  - CFG_HI: a data byte is captured as hi byte -> HUNT, with config completion; lacr_val <= {hi, lo}, lacr_stb pulses.
  - Any K character in CFG_LO/CFG_HI: K28.5 -> K, otherwise -> HUNT. No strobe.
  - rx_err=1 on any byte: FSM -> HUNT regardless of state or byte value; the byte is ignored and no strobe is issued.
- Completion (config or idle) is called a "valid set".
- The strobe on a config completion is unconditional, even when the value repeats; match counting is downstream's job.
- lacr_val holds its value between strobes. An all-zero word (breaklink) is delivered like any other word.
- err_cnt, 4 bits:
  - +1 per rx_err cycle, saturating at ERR_LIMIT.
  - Cleared on a valid set.
  - If rx_err coincides with what would have completed a set, the error wins: count +1, no completion.
- comma_timer, 16 bits:
  - Cleared on a valid set.
  - Otherwise +1 per cycle, saturating at COMMA_TIMEOUT.
- los:
  - Set when err_cnt==ERR_LIMIT or comma_timer==COMMA_TIMEOUT.
  - Cleared on a valid set. When set and clear conditions coincide, clear wins, because the counters clear on the same event.

## Timing

- Reset values: lacr_val=0, lacr_stb=0, idle_stb=0, los=1, FSM=HUNT, err_cnt=0, comma_timer=0.
- All outputs are registered.
- lacr_stb / idle_stb rise the cycle after the completing byte is sampled. Latency is 1 cycle from the last byte of the set.
- Back-to-back config sets: one lacr_stb per 4 bytes minimum. Strobes are never adjacent.
- los:
  - Deasserts the cycle after the completing byte of a valid set, coincident with the strobe.
  - Asserts on the cycle the terminating counter condition becomes true, plus one register stage.
- comma_timer saturates with no wrap-around. los stays high indefinitely with no input activity.
- Asynchronous reset mid-set discards the partial word. The next set must start with K28.5.

## Test plan

- Config capture: after reset, send BC(K) B5 20 40 -> lacr_val=0x4020, lacr_stb high exactly 1 cycle, 1 cycle after byte 0x40; los 1->0 same cycle.
- /C2/ and repetition:
  - Send BC(K) 42 20 00 three times -> three strobes, lacr_val=0x0020 each time, strobes 4 cycles apart.
  - Send BC(K) B5 00 00 -> strobe with lacr_val=0x0000.
- Idle: send BC(K) C5 and BC(K) 50 alternately -> idle_stb per pair, no lacr_stb, lacr_val unchanged.
- Aborts:
  - BC(K) B5 20 then rx_err on the hi byte -> no strobe, lacr_val unchanged, err_cnt=1.
  - BC(K) B5 BC(K) B5 11 22 -> a single strobe with 0x2211.
- LOS by errors: ERR_LIMIT=4, 4 rx_err cycles between idles with no valid set -> los=1; next BC C5 -> los=0.
- LOS by timeout: COMMA_TIMEOUT=16, constant 0x00 data for 16 cycles -> los=1 and held; then assert rst mid-set -> all outputs return to reset values asynchronously.
